st_ctrl: RTL

- Sequencer for the store (ST-family, commands 24-31) field-merge datapath.
- Runs one read-modify-write per store on the single-port main memory, which is shared with other units through an external arbiter (req/gnt).
- On each accepted store it checks the field, reads the old word, steps the merge datapath through its two-cycle start/output sequence, writes the merged word back, and reports done or error.

---
 rtl/st_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/st_ctrl.sv
// Store (ST-family) sequencer: one atomic read-modify-write per accepted store,
// stepping the external field-merge datapath between the memory read and write.
module st_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int WORD_W  = 31,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        field,
  input  logic [ADDR_W-1:0] addressin,
  input  logic [WORD_W-1:0] src,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mrg_start,
  output logic [5:0]        mrg_field,
  output logic [WORD_W-1:0] mrg_in,
  output logic [ADDR_W-1:0] mrg_addr,
  output logic [WORD_W-1:0] mrg_data,
  input  logic [WORD_W-1:0] mrg_out
);

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    REQ,
    WAIT,
    MERGE,
    WRITE,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_src;
  logic [5:0]          r_field;
  logic [WORD_W-1:0]   r_old;
  logic [WORD_W-1:0]   r_merged;
  logic [2:0]          r_cnt;
  logic                r_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic                w_legal;
  logic                w_rd_last;

  assign w_legal   = (r_field[5:3] <= r_field[2:0]) && (r_field[2:0] <= 3'd5);
  assign w_rd_last = (r_state == WAIT) && (r_cnt == 3'd1);

  assign mrg_field = r_field;
  assign mrg_in    = r_src;
  assign mrg_addr  = r_addr;

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mrg_start = 1'b0;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    mrg_data  = r_old;
    case (r_state)
      IDLE: begin
        if (start) w_next = CHK;
      end
      CHK: begin
        busy   = 1'b1;
        w_next = w_legal ? REQ : DONE;
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          mem_re   = 1'b1;
          mem_addr = r_addr;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        // Old word bypassed so the datapath sees it in the start cycle as well.
        if (w_rd_last) begin
          mrg_start = 1'b1;
          mrg_data  = mem_rdata;
          w_next    = MERGE;
        end
      end
      MERGE: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        w_next  = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          mem_we    = 1'b1;
          mem_addr  = r_addr;
          mem_wdata = r_merged;
          w_next    = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_src       <= '0;
      r_field     <= '0;
      r_old       <= '0;
      r_merged    <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_addr  <= addressin;
        r_src   <= src;
        r_field <= field;
      end
      if (r_state == CHK) r_err <= !w_legal;
      if (r_state == REQ && mem_gnt) r_cnt <= 3'(MEM_LAT);
      if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
      if (w_rd_last) r_old <= mem_rdata;
      if (r_state == MERGE) r_merged <= mrg_out;
      if (mem_re || mem_we) r_mem_addr <= r_addr;
      if (mem_we) r_mem_wdata <= r_merged;
    end
  end

endmodule
